// File: rtl/btn_debounce_if.sv
// Button-conditioning bus: raw button inputs toward the debouncer, clean
// levels, press/release pulses and the shared sample tick back out.
interface btn_debounce_if #(
  parameter int N = 6
);
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic         tick;

  // Board side: drives raw buttons, consumes conditioned outputs.
  modport master (
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  tick
  );

  // Debouncer side.
  modport slave (
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release,
    output tick
  );
endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser per channel, one shared
// prescaler tick, and a per-channel four-state stability filter that commits
// a new level only after STABLE_TICKS consecutive ticks of a steady input.
module btn_debounce #(
  parameter int N            = 6,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 20
) (
  input  logic          clk,
  input  logic          rst,
  btn_debounce_if.slave bus_io
);

  // A divide-by-one prescaler still needs a 1-bit register to exist.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(STABLE_TICKS + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(STABLE_TICKS - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [SW-1:0] STB_ONE  = SW'(1);

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_WAIT_H = 2'd1,
    ST_HIGH   = 2'd2,
    ST_WAIT_L = 2'd3
  } state_t;

  logic [N-1:0]  meta_q;
  logic [N-1:0]  sync_q;

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  logic          tick_q;
  logic          tick_d;

  state_t        state_q [N];
  state_t        state_d [N];
  logic [SW-1:0] cnt_q   [N];
  logic [SW-1:0] cnt_d   [N];

  logic [N-1:0]  level_q;
  logic [N-1:0]  level_d;
  logic [N-1:0]  press_q;
  logic [N-1:0]  press_d;
  logic [N-1:0]  release_q;
  logic [N-1:0]  release_d;

  // Bring the asynchronous button lines into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= bus_io.btn_in;
      sync_q <= meta_q;
    end
  end

  // Prescaler next value; tick is registered so it lines up with the count.
  always_comb begin
    pre_d = '0;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PRE_ONE;
    end
    tick_d = (pre_d == PRE_LAST);
  end

  // Prescaler counter and tick register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  // Per-channel filter: next state, stability count and commit pulses.
  always_comb begin
    level_d   = '0;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_LOW: begin
          if (sync_q[i]) begin
            state_d[i] = ST_WAIT_H;
            cnt_d[i]   = '0;
          end else begin
            state_d[i] = ST_LOW;
          end
        end
        ST_WAIT_H: begin
          // A dropout restarts the filter even if a tick lands this cycle.
          if (!sync_q[i]) begin
            state_d[i] = ST_LOW;
            cnt_d[i]   = '0;
          end else if (tick_q) begin
            if (cnt_q[i] == STB_LAST) begin
              state_d[i] = ST_HIGH;
              cnt_d[i]   = '0;
              press_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + STB_ONE;
            end
          end else begin
            cnt_d[i] = cnt_q[i];
          end
        end
        ST_HIGH: begin
          if (!sync_q[i]) begin
            state_d[i] = ST_WAIT_L;
            cnt_d[i]   = '0;
          end else begin
            state_d[i] = ST_HIGH;
          end
        end
        ST_WAIT_L: begin
          if (sync_q[i]) begin
            state_d[i] = ST_HIGH;
            cnt_d[i]   = '0;
          end else if (tick_q) begin
            if (cnt_q[i] == STB_LAST) begin
              state_d[i]   = ST_LOW;
              cnt_d[i]     = '0;
              release_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + STB_ONE;
            end
          end else begin
            cnt_d[i] = cnt_q[i];
          end
        end
        default: begin
          state_d[i] = ST_LOW;
          cnt_d[i]   = '0;
        end
      endcase
      // Level follows the committed side, so it moves on the commit edge.
      level_d[i] = (state_d[i] == ST_HIGH) || (state_d[i] == ST_WAIT_L);
    end
  end

  // Filter state, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= ST_LOW;
        cnt_q[i]   <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign bus_io.btn_level   = level_q;
  assign bus_io.btn_press   = press_q;
  assign bus_io.btn_release = release_q;
  assign bus_io.tick        = tick_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random button activity,
// checked every cycle against a cycle-level behavioural model, and a second
// instance exercising the divide-by-one / single-tick corner.
module tb_btn_debounce;
  localparam int N  = 6;
  localparam int DA = 4;
  localparam int SA = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   n;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  btn_debounce_if #(.N(N)) a_if ();
  btn_debounce_if #(.N(N)) b_if ();

  btn_debounce #(.N(N), .TICK_DIV(DA), .STABLE_TICKS(SA)) dut_a (
    .clk(clk), .rst(rst), .bus_io(a_if.slave)
  );

  btn_debounce #(.N(N), .TICK_DIV(1), .STABLE_TICKS(1)) dut_b (
    .clk(clk), .rst(rst), .bus_io(b_if.slave)
  );

  // Reference model for dut_a: inputs are seen two clocks late; a channel whose
  // seen input differs from its level starts a pending change, counts the ticks
  // that follow while the difference persists, and commits on the SA-th tick.
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_prs = '0, m_rel = '0;
  logic         m_tick = 1'b0;
  int unsigned  m_ec = 0;
  bit           m_pend [N];
  int           m_tks  [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0;
      m_tks[i]  = 0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0;
        m_tick = 1'b0; m_ec = 0;
        for (int i = 0; i < N; i++) begin
          m_pend[i] = 1'b0;
          m_tks[i]  = 0;
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          m_prs[i] = 1'b0;
          m_rel[i] = 1'b0;
          if (m_s2[i] == m_lvl[i]) begin
            m_pend[i] = 1'b0;
          end else if (!m_pend[i]) begin
            m_pend[i] = 1'b1;
            m_tks[i]  = 0;
          end else if (m_tick) begin
            m_tks[i] = m_tks[i] + 1;
            if (m_tks[i] == SA) begin
              m_lvl[i]  = m_s2[i];
              m_prs[i]  = m_s2[i];
              m_rel[i]  = ~m_s2[i];
              m_pend[i] = 1'b0;
            end
          end
        end
        m_s2   = m_s1;
        m_s1   = a_if.btn_in;
        m_ec   = m_ec + 1;
        m_tick = ((m_ec % DA) == DA - 1);
      end
    end
  end

  // Cycle-by-cycle comparison of dut_a against the model, just after each edge.
  initial begin
    wait (mon_en);
    forever begin
      @(posedge clk);
      #1;
      checks++;
      assert ({a_if.btn_level, a_if.btn_press, a_if.btn_release, a_if.tick}
              === {m_lvl, m_prs, m_rel, m_tick})
      else begin
        errors++;
        $error("FAIL model_cmp t=%0t observed lvl/prs/rel/tick=%h/%h/%h/%b expected %h/%h/%h/%b",
               $time, a_if.btn_level, a_if.btn_press, a_if.btn_release, a_if.tick,
               m_lvl, m_prs, m_rel, m_tick);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Count falling edges until the selected pulse of dut_a appears (bounded).
  task automatic wait_pulse(input int ch, input bit rel, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(rel ? a_if.btn_release[ch] : a_if.btn_press[ch]) && cnt < 25);
  endtask

  initial begin
    int idx;
    a_if.btn_in = '1;
    b_if.btn_in = '0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    mon_en = 1'b1;
    chk("in_reset_zero", {a_if.btn_level, a_if.btn_press, a_if.btn_release, a_if.tick}, 32'd0);
    chk("in_reset_zero_b", {b_if.btn_level, b_if.btn_press, b_if.btn_release, b_if.tick}, 32'd0);

    // Buttons held through reset release: accepted as a normal press.
    rst = 1'b0;
    @(negedge clk);
    chk("first_cycle_zero", {a_if.btn_level, a_if.btn_press, a_if.btn_release}, 32'd0);
    n = 1;
    while (a_if.btn_press !== 6'h3f && n < 25) begin
      @(negedge clk);
      n++;
    end
    chk_rng("rst_press_lat", n, 11, 15);
    chk("rst_press_all", a_if.btn_press, 32'h3f);
    @(negedge clk);
    chk("rst_level_all", a_if.btn_level, 32'h3f);
    chk("rst_press_single", a_if.btn_press, 32'h00);

    a_if.btn_in = '0;
    wait_pulse(0, 1'b1, n);
    chk_rng("all_release_lat", n, 11, 15);
    chk("all_release_vec", a_if.btn_release, 32'h3f);
    repeat (5) @(negedge clk);

    // Clean press and release on channel 0.
    a_if.btn_in[0] = 1'b1;
    wait_pulse(0, 1'b0, n);
    chk_rng("clean_press_lat", n, 11, 15);
    chk("clean_press_vec", a_if.btn_press, 32'h01);
    repeat (40 - n) @(negedge clk);
    a_if.btn_in[0] = 1'b0;
    wait_pulse(0, 1'b1, n);
    chk_rng("clean_release_lat", n, 11, 15);
    chk("clean_release_vec", a_if.btn_release, 32'h01);
    chk("clean_no_press", a_if.btn_press, 32'h00);
    repeat (5) @(negedge clk);

    // Bounce on channel 2, then a steady hold.
    for (int k = 0; k < 10; k++) begin
      a_if.btn_in[2] = ~a_if.btn_in[2];
      repeat (3) @(negedge clk);
      chk("bounce_level2", a_if.btn_level[2], 32'd0);
    end
    a_if.btn_in[2] = 1'b1;
    wait_pulse(2, 1'b0, n);
    chk_rng("bounce_press_lat", n, 11, 15);
    @(negedge clk);
    chk("bounce_level_end", a_if.btn_level[2], 32'd1);

    // Short glitch on channel 3.
    a_if.btn_in[3] = 1'b1;
    repeat (5) @(negedge clk);
    a_if.btn_in[3] = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_level3", a_if.btn_level[3], 32'd0);

    // Reset while channel 1 is still filtering.
    a_if.btn_in[1] = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_no_press", a_if.btn_press[1], 32'd0);
    chk("midrst_level", a_if.btn_level[1], 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_cleared", {a_if.btn_level, a_if.btn_press, a_if.btn_release}, 32'd0);
    rst = 1'b0;
    wait_pulse(1, 1'b0, n);
    chk_rng("midrst_press_lat", n, 11, 15);

    // Random activity, checked cycle by cycle against the model.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, N - 1);
        a_if.btn_in[idx] = ~a_if.btn_in[idx];
      end
    end

    // Divide-by-one, single-tick corner.
    chk("b_tick_high", b_if.tick, 32'd1);
    b_if.btn_in[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      chk("b_tick_const", b_if.tick, 32'd1);
    end while (!b_if.btn_press[0] && n < 10);
    chk("b_press_lat", n, 32'd4);
    chk("b_level", b_if.btn_level[0], 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
